// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a binary source and the sequential BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
);
    logic                  START;
    logic [IN_W-1:0]       DATA;
    logic                  BLANK;
    logic                  BUSY;
    logic                  DONE;
    logic [4*DIGITS-1:0]   BCD;
    logic [DIGITS-1:0]     BLANK_MASK;
    logic                  OVF;

    modport master (
        output START, DATA, BLANK,
        input  BUSY, DONE, BCD, BLANK_MASK, OVF
    );

    modport slave (
        input  START, DATA, BLANK,
        output BUSY, DONE, BCD, BLANK_MASK, OVF
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with leading-zero blanking mask and saturation on overflow.
module bin_to_bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic              CLK,
    input  logic              RST,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int WORK_W = 4 * DIGITS;
    localparam int COMB_W = WORK_W + IN_W;
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam logic [WORK_W-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [IN_W-1:0]     shift_q,  shift_d;
    logic [WORK_W-1:0]   work_q,   work_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                blank_q,  blank_d;
    logic                sticky_q, sticky_d;
    logic [WORK_W-1:0]   bcd_q,    bcd_d;
    logic [DIGITS-1:0]   mask_q,   mask_d;
    logic                ovf_q,    ovf_d;

    logic [WORK_W-1:0]   work_adj;
    logic [COMB_W-1:0]   combo;
    logic [COMB_W-1:0]   combo_sh;
    logic [WORK_W-1:0]   work_sh;
    logic [IN_W-1:0]     shift_sh;
    logic                carry_out;
    logic [DIGITS-1:0]   digit_big;
    logic [DIGITS-1:0]   upper_zero;
    logic [DIGITS-1:0]   mask_calc;
    logic                final_ovf;

    // Add-3 correction on every work digit before the shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5)
                                         ? (work_q[4*gi +: 4] + 4'd3)
                                         : work_q[4*gi +: 4];
        end
    endgenerate

    assign combo     = {work_adj, shift_q};
    assign combo_sh  = {combo[COMB_W-2:0], 1'b0};
    assign carry_out = combo[COMB_W-1];
    assign work_sh   = combo_sh[COMB_W-1:IN_W];
    assign shift_sh  = combo_sh[IN_W-1:0];

    // upper_zero[i]: digits i..DIGITS-1 of the post-shift work value are all zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_big[gi]  = (work_sh[4*gi +: 4] > 4'd9);
            assign upper_zero[gi] = (work_sh[WORK_W-1:4*gi] == '0);
            if (gi == 0) begin : g_units
                assign mask_calc[gi] = 1'b0;
            end else begin : g_upper
                assign mask_calc[gi] = blank_q & upper_zero[gi];
            end
        end
    endgenerate

    assign final_ovf = sticky_q | carry_out | (|digit_big);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            blank_q  <= 1'b0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            mask_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            blank_q  <= blank_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            mask_q   <= mask_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        blank_d  = blank_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        mask_d   = mask_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    shift_d  = bus.DATA;
                    blank_d  = bus.BLANK;
                    work_d   = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_W'(IN_W);
                    state_d  = CONV;
                end
            end
            CONV: begin
                work_d   = work_sh;
                shift_d  = shift_sh;
                cnt_d    = cnt_q - 1'b1;
                sticky_d = sticky_q | carry_out;
                // Result registers load on the last shift so they are valid throughout FIN.
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = FIN;
                    sticky_d = final_ovf;
                    ovf_d    = final_ovf;
                    bcd_d    = final_ovf ? NINES : work_sh;
                    mask_d   = final_ovf ? '0 : mask_calc;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DONE       = (state_q == FIN);
    assign bus.BCD        = bcd_q;
    assign bus.BLANK_MASK = mask_q;
    assign bus.OVF        = ovf_q;

endmodule
